// File: rtl/ofdm_pkg.sv
// Shared constants and types for the OFDM 16-QAM symbol scheduler.
// Level values are unsigned 16-bit amplitude codes consumed by the symbol generator.
package ofdm_pkg;

    localparam logic [15:0] LVL_0A = 16'h000A;
    localparam logic [15:0] LVL_14 = 16'h0014;
    localparam logic [15:0] LVL_1E = 16'h001E;
    localparam logic [15:0] LVL_28 = 16'h0028;

    localparam logic [15:0] PILOT_I = LVL_28;
    localparam logic [15:0] PILOT_Q = LVL_28;

    localparam int LANE_BITS = 16;

    typedef enum logic {
        ACCEPT = 1'b0,
        STALL  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/qam16_lane_map.sv
// Combinational 16-QAM nibble mapper: bits [1:0] select the I level, bits [3:2] the Q level.
module qam16_lane_map
    import ofdm_pkg::*;
(
    input  logic [3:0]  in_data,
    output logic [15:0] i_lvl,
    output logic [15:0] q_lvl
);

    always_comb begin
        i_lvl = LVL_14;
        q_lvl = LVL_28;
        case (in_data[1:0])
            2'b00:   i_lvl = LVL_14;
            2'b01:   i_lvl = LVL_0A;
            2'b10:   i_lvl = LVL_28;
            default: i_lvl = LVL_1E;
        endcase
        case (in_data[3:2])
            2'b00:   q_lvl = LVL_28;
            2'b01:   q_lvl = LVL_1E;
            2'b10:   q_lvl = LVL_14;
            default: q_lvl = LVL_0A;
        endcase
    end

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Packs mapped 16-QAM nibbles into LANES-wide I/Q words, marks OFDM symbol ends and counts symbols.
// Optional build macro OFDM_PILOT_INSERT_EN puts a fixed pilot in lane 0 of every word.
module ofdm_symbol_scheduler
    import ofdm_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int WORDS_PER_SYM = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [3:0]                 in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*LANE_BITS-1:0] out_phase,
    output logic [LANES*LANE_BITS-1:0] out_quad,
    output logic                       out_last,
    output logic [15:0]                sym_count
);

    localparam int WORD_W  = LANES * LANE_BITS;
    localparam int LANE_CW = $clog2(LANES);
    localparam int WCNT_W  = $clog2(WORDS_PER_SYM);

`ifdef OFDM_PILOT_INSERT_EN
    localparam logic [LANE_CW-1:0] FIRST_LANE = LANE_CW'(1);
`else
    localparam logic [LANE_CW-1:0] FIRST_LANE = '0;
`endif
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);
    localparam logic [WCNT_W-1:0]  LAST_WORD = WCNT_W'(WORDS_PER_SYM - 1);

    sched_state_t        state, state_nx;
    logic [LANE_CW-1:0]  lane_cnt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [WORD_W-1:0]   fill_i, fill_q;
    logic [WORD_W-1:0]   asm_i, asm_q;
    logic [15:0]         map_i, map_q;
    logic                accept, out_hs, out_free, word_done;
    logic                load_direct, load_fill, load;

    qam16_lane_map u_map (
        .in_data (in_data),
        .i_lvl   (map_i),
        .q_lvl   (map_q)
    );

    assign in_ready    = (state == ACCEPT);
    assign accept      = in_valid && in_ready && !clr;
    assign out_hs      = out_valid && out_ready;
    assign out_free    = !out_valid || out_ready;
    assign word_done   = accept && (lane_cnt == LAST_LANE);
    assign load_direct = word_done && out_free;
    assign load_fill   = (state == STALL) && out_hs && !clr;
    assign load        = load_direct || load_fill;

    // Fill word with the incoming nibble merged in, so a completing nibble can bypass straight to the output.
    always_comb begin
        asm_i = fill_i;
        asm_q = fill_q;
        asm_i[int'(lane_cnt)*LANE_BITS +: LANE_BITS] = map_i;
        asm_q[int'(lane_cnt)*LANE_BITS +: LANE_BITS] = map_q;
`ifdef OFDM_PILOT_INSERT_EN
        asm_i[LANE_BITS-1:0] = PILOT_I;
        asm_q[LANE_BITS-1:0] = PILOT_Q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCEPT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCEPT:  if (word_done && !out_free) state_nx = STALL;
            STALL:   if (clr || out_hs)          state_nx = ACCEPT;
            default: state_nx = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= FIRST_LANE;
            word_cnt <= '0;
        end else if (clr) begin
            lane_cnt <= FIRST_LANE;
            word_cnt <= '0;
        end else begin
            if (accept)
                lane_cnt <= word_done ? FIRST_LANE : lane_cnt + LANE_CW'(1);
            if (load)
                word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WCNT_W'(1);
        end
    end

    // Fill buffer is pure data; every lane is rewritten before a word can complete.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_i <= asm_i;
            fill_q <= asm_q;
        end
    end

    // Output stage: holds steady under backpressure, reloads back-to-back on a concurrent handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_phase <= '0;
            out_quad  <= '0;
            out_last  <= 1'b0;
            sym_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_phase <= load_fill ? fill_i : asm_i;
                out_quad  <= load_fill ? fill_q : asm_q;
                out_last  <= (word_cnt == LAST_WORD);
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs && out_last)
                sym_count <= sym_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Directed bench for ofdm_symbol_scheduler (default build, no pilot insertion).
module tb_ofdm_symbol_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'h0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_phase;
    logic [63:0] out_quad;
    logic        out_last;
    logic [15:0] sym_count;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    bit sent_done;
    int nwords, nlast, last0, last1;

    ofdm_symbol_scheduler #(.LANES(4), .WORDS_PER_SYM(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_phase (out_phase),
        .out_quad  (out_quad),
        .out_last  (out_last),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the nibble is taken.
    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_phase", out_phase, 64'd0);
        check("rst_out_quad",  out_quad,  64'd0);
        check("rst_out_last",  {63'd0, out_last},  64'd0);
        check("rst_sym_count", {48'd0, sym_count}, 64'd0);

        // nibbles 0..3 with free output
        send(4'h0); send(4'h1); send(4'h2); send(4'h3);
        check("w1_valid", {63'd0, out_valid}, 64'd1);
        check("w1_phase", out_phase, 64'h001E_0028_000A_0014);
        check("w1_quad",  out_quad,  64'h0028_0028_0028_0028);
        check("w1_last",  {63'd0, out_last}, 64'd0);
        @(negedge clk);
        check("w1_drained", {63'd0, out_valid}, 64'd0);

        send(4'hF); send(4'hF); send(4'hF); send(4'hF);
        check("wf_phase", out_phase, 64'h001E_001E_001E_001E);
        check("wf_quad",  out_quad,  64'h000A_000A_000A_000A);
        @(negedge clk);

        // backpressure across two words
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(4'(k));
        check("bp_in_ready", {63'd0, in_ready},  64'd0);
        check("bp_valid",    {63'd0, out_valid}, 64'd1);
        check("bp_a_phase",  out_phase, 64'h001E_0028_000A_0014);
        check("bp_a_quad",   out_quad,  64'h0028_0028_0028_0028);
        repeat (3) @(negedge clk);
        check("bp_hold_quad",  out_quad, 64'h0028_0028_0028_0028);
        check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_valid", {63'd0, out_valid}, 64'd1);
        check("bp_b_phase", out_phase, 64'h001E_0028_000A_0014);
        check("bp_b_quad",  out_quad,  64'h001E_001E_001E_001E);
        check("bp_b_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // clr after two nibbles, coinciding with a nibble that must be dropped
        send(4'h3); send(4'h3);
        in_valid = 1'b1; in_data = 4'hF; clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        send(4'h5); send(4'h6); send(4'h7); send(4'h4);
        check("clr_valid", {63'd0, out_valid}, 64'd1);
        check("clr_phase", out_phase, 64'h0014_001E_0028_000A);
        check("clr_quad",  out_quad,  64'h001E_001E_001E_001E);
        @(negedge clk);

        // two full symbols with random backpressure
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("pre_stream_sym", {48'd0, sym_count}, 64'd0);
        sent_done = 1'b0;
        nwords = 0; nlast = 0; last0 = -1; last1 = -1;
        fork
            begin
                for (int n = 0; n < 128; n++) send(4'(n));
                sent_done = 1'b1;
            end
            begin
                while (!sent_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                for (int c = 0; c < 8000 && nwords < 32; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            if (nlast == 0) last0 = nwords;
                            else            last1 = nwords;
                            nlast++;
                        end
                        nwords++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("stream_words", 64'(nwords), 64'd32);
        check("stream_nlast", 64'(nlast),  64'd2);
        check("stream_last0", 64'(last0),  64'd15);
        check("stream_last1", 64'(last1),  64'd31);
        check("stream_sym",   {48'd0, sym_count}, 64'd2);

        // asynchronous reset with a held word and a partial word
        out_ready = 1'b0;
        send(4'h0); send(4'h1); send(4'h2); send(4'h3);
        send(4'h5); send(4'h6);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_phase", out_phase, 64'd0);
        check("arst_quad",  out_quad,  64'd0);
        check("arst_last",  {63'd0, out_last},  64'd0);
        check("arst_sym",   {48'd0, sym_count}, 64'd0);
        check("arst_ready", {63'd0, in_ready},  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(4'h0); send(4'h1); send(4'h2); send(4'h3);
        check("post_rst_phase", out_phase, 64'h001E_0028_000A_0014);
        check("post_rst_quad",  out_quad,  64'h0028_0028_0028_0028);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
